// File: rtl/cacheline_req_sched_pkg.sv
// Shared constants and types for the cacheline request scheduler.
package cacheline_req_sched_pkg;

    // Cacheline geometry: tag/address width and way count of the lookup stage.
    localparam int CL_ADDR_WIDTH = 32;
    localparam int CL_NUM_WAYS   = 8;

    // Scheduler phases: normal issue, quiesce before a domain switch, and the
    // single cycle in which os_req is presented to the cacheline.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } sched_state_e;

endpackage : cacheline_req_sched_pkg

// File: rtl/cacheline_req_fifo.sv
// Small request queue. The pointers carry one extra MSB so that full and
// empty can be told apart without a separate occupancy counter. The head
// entry is visible combinationally, so a pop can be issued in the same cycle.
module cacheline_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A full queue refuses a push even when a pop frees a slot this cycle.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule : cacheline_req_fifo

// File: rtl/cacheline_req_sched.sv
// Request scheduler in front of the cacheline lookup stage. Queues user
// lookups, drives os_req/hitmap/user_req/addr, sequences domain switches
// (quiesce, one os_req cycle, resume) and keeps per-domain hit/miss counts.
module cacheline_req_sched
    import cacheline_req_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = CL_ADDR_WIDTH,
    parameter int NUM_WAYS   = CL_NUM_WAYS,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  os_valid,
    input  logic [NUM_WAYS-1:0]   os_hitmap,
    output logic                  os_ready,
    output logic                  os_err,
    input  logic                  user_valid,
    input  logic [ADDR_WIDTH-1:0] user_addr,
    input  logic [ID_WIDTH-1:0]   user_id,
    output logic                  user_ready,
    output logic                  os_req,
    output logic [NUM_WAYS-1:0]   hitmap,
    output logic                  user_req,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic                  hit,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic                  domain_valid,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    localparam int FW = ADDR_WIDTH + ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    sched_state_e          state_q, state_d;
    logic [NUM_WAYS-1:0]   pend_hitmap_q, pend_hitmap_d;
    logic                  os_req_q, os_req_d;
    logic [NUM_WAYS-1:0]   hitmap_q, hitmap_d;
    logic                  os_err_q, os_err_d;
    logic                  domain_valid_q, domain_valid_d;
    logic                  user_req_q, user_req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [FW-1:0]         fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Handshakes. OS commands win over user lookups in the same cycle, and
    // nothing is accepted while reset is held.
    assign os_ready   = (state_q == ST_RUN) && !reset;
    assign user_ready = (state_q == ST_RUN) && !fifo_full && domain_valid_q &&
                        !os_valid && !reset;
    assign fifo_push  = user_valid && user_ready;
    // Keep issuing during DRAIN so the switch waits only for real work.
    assign fifo_pop   = (state_q != ST_SWITCH) && !fifo_empty;

    cacheline_req_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({user_addr, user_id}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // FSM, issue stage, response stage and counters next-state logic.
    always_comb begin
        state_d        = state_q;
        pend_hitmap_d  = pend_hitmap_q;
        os_req_d       = 1'b0;
        hitmap_d       = hitmap_q;
        os_err_d       = 1'b0;
        domain_valid_d = domain_valid_q;
        user_req_d     = 1'b0;
        addr_d         = addr_q;
        id_d           = id_q;
        resp_valid_d   = user_req_q;
        resp_id_d      = id_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;

        // Issue the queue head to the cacheline.
        if (fifo_pop) begin
            user_req_d = 1'b1;
            addr_d     = fifo_head[FW-1:ID_WIDTH];
            id_d       = fifo_head[ID_WIDTH-1:0];
        end

        // Count completed lookups, holding at all-ones.
        if (resp_valid_q) begin
            if (hit) begin
                if (hit_cnt_q != CNT_MAX) begin
                    hit_cnt_d = hit_cnt_q + CNT_ONE;
                end
            end else begin
                if (miss_cnt_q != CNT_MAX) begin
                    miss_cnt_d = miss_cnt_q + CNT_ONE;
                end
            end
        end

        case (state_q)
            ST_RUN: begin
                if (os_valid) begin
                    if (os_hitmap != '0) begin
                        pend_hitmap_d = os_hitmap;
                        state_d       = ST_DRAIN;
                    end else begin
                        // An empty way mask is meaningless; drop it and flag it.
                        os_err_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Switch only once nothing is queued, issued or awaiting a result.
                if (fifo_empty && !user_req_q && !resp_valid_q) begin
                    state_d  = ST_SWITCH;
                    os_req_d = 1'b1;
                    hitmap_d = pend_hitmap_q;
                end
            end
            ST_SWITCH: begin
                state_d        = ST_RUN;
                domain_valid_d = 1'b1;
                hit_cnt_d      = '0;
                miss_cnt_d     = '0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers; reset drops all queued and in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            pend_hitmap_q  <= '0;
            os_req_q       <= 1'b0;
            hitmap_q       <= '0;
            os_err_q       <= 1'b0;
            domain_valid_q <= 1'b0;
            user_req_q     <= 1'b0;
            addr_q         <= '0;
            id_q           <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            pend_hitmap_q  <= pend_hitmap_d;
            os_req_q       <= os_req_d;
            hitmap_q       <= hitmap_d;
            os_err_q       <= os_err_d;
            domain_valid_q <= domain_valid_d;
            user_req_q     <= user_req_d;
            addr_q         <= addr_d;
            id_q           <= id_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    assign os_req       = os_req_q;
    assign hitmap       = hitmap_q;
    assign os_err       = os_err_q;
    assign domain_valid = domain_valid_q;
    assign user_req     = user_req_q;
    assign addr         = addr_q;
    assign resp_valid   = resp_valid_q;
    // The cacheline returns hit in the cycle after user_req, which is the
    // cycle the response stage is valid, so it is passed straight through.
    assign resp_hit     = resp_valid_q & hit;
    assign resp_id      = resp_id_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule : cacheline_req_sched

// File: tb/tb_cacheline_req_sched.sv
// Directed bench for cacheline_req_sched (2-bit counters to reach saturation).
module tb_cacheline_req_sched;

    localparam int AW = 32;
    localparam int NW = 8;
    localparam int IW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          os_valid;
    logic [NW-1:0] os_hitmap;
    logic          os_ready;
    logic          os_err;
    logic          user_valid;
    logic [AW-1:0] user_addr;
    logic [IW-1:0] user_id;
    logic          user_ready;
    logic          os_req;
    logic [NW-1:0] hitmap;
    logic          user_req;
    logic [AW-1:0] addr;
    logic          hit;
    logic          resp_valid;
    logic          resp_hit;
    logic [IW-1:0] resp_id;
    logic          domain_valid;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cacheline_req_sched #(
        .ADDR_WIDTH (AW),
        .NUM_WAYS   (NW),
        .FIFO_DEPTH (4),
        .ID_WIDTH   (IW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .os_valid     (os_valid),
        .os_hitmap    (os_hitmap),
        .os_ready     (os_ready),
        .os_err       (os_err),
        .user_valid   (user_valid),
        .user_addr    (user_addr),
        .user_id      (user_id),
        .user_ready   (user_ready),
        .os_req       (os_req),
        .hitmap       (hitmap),
        .user_req     (user_req),
        .addr         (addr),
        .hit          (hit),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_id      (resp_id),
        .domain_valid (domain_valid),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_t3 [6];
        int exp_t4 [6];
        exp_t3 = '{-1, -1, 3, 4, 5, 6};
        exp_t4 = '{-1, -1, 8, 9, 10, -1};

        reset      = 1'b1;
        os_valid   = 1'b0;
        os_hitmap  = '0;
        user_valid = 1'b0;
        user_addr  = '0;
        user_id    = '0;
        hit        = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_os_ready", os_ready, 0);
        chk("rst_os_req", os_req, 0);
        chk("rst_hitmap", hitmap, 0);
        chk("rst_user_req", user_req, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_domain_valid", domain_valid, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_os_err", os_err, 0);
        $display("T0 reset checked");

        reset = 1'b0;
        #1;
        chk("run_os_ready", os_ready, 1);

        // No lookup accepted before the first domain
        user_valid = 1'b1;
        #1;
        chk("nodomain_user_ready", user_ready, 0);
        user_valid = 1'b0;

        // First domain switch to 8'h0F
        os_valid  = 1'b1;
        os_hitmap = 8'h0F;
        #1;
        chk("os_prio_user_ready", user_ready, 0);
        tick();
        os_valid = 1'b0;
        chk("drain_os_ready", os_ready, 0);
        tick();
        chk("sw1_os_req", os_req, 1);
        chk("sw1_hitmap", hitmap, 8'h0F);
        chk("sw1_user_req", user_req, 0);
        chk("sw1_domain_valid", domain_valid, 0);
        tick();
        chk("sw1_os_req_off", os_req, 0);
        chk("sw1_hitmap_hold", hitmap, 8'h0F);
        chk("sw1_domain_valid_on", domain_valid, 1);
        chk("sw1_os_ready", os_ready, 1);
        $display("T1 domain 0F committed");

        // Two lookups to addr 5: id1 misses, id2 hits
        user_valid = 1'b1;
        user_addr  = 32'd5;
        user_id    = 4'd1;
        #1;
        chk("t2_user_ready", user_ready, 1);
        tick();
        user_id = 4'd2;
        tick();
        user_valid = 1'b0;
        chk("t2_user_req", user_req, 1);
        chk("t2_addr", addr, 5);
        chk("t2_resp_early", resp_valid, 0);
        tick();
        chk("t2_resp1_valid", resp_valid, 1);
        chk("t2_resp1_id", resp_id, 1);
        chk("t2_resp1_hit", resp_hit, 0);
        chk("t2_user_req2", user_req, 1);
        tick();
        hit = 1'b1;
        #1;
        chk("t2_resp2_valid", resp_valid, 1);
        chk("t2_resp2_id", resp_id, 2);
        chk("t2_resp2_hit", resp_hit, 1);
        chk("t2_miss_cnt", miss_cnt, 1);
        tick();
        hit = 1'b0;
        chk("t2_resp_done", resp_valid, 0);
        chk("t2_hit_cnt", hit_cnt, 1);
        chk("t2_miss_cnt_hold", miss_cnt, 1);
        $display("T2 two lookups hit=%0d miss=%0d", hit_cnt, miss_cnt);

        // Four back-to-back lookups, all hits; hit_cnt saturates at 3
        hit = 1'b1;
        for (int c = 0; c < 6; c++) begin
            user_valid = (c < 4);
            user_addr  = 32'(16 + c);
            user_id    = IW'(3 + c);
            if (c < 4) begin
                #1;
                chk("t3_user_ready", user_ready, 1);
            end
            tick();
            if (exp_t3[c] >= 0) begin
                chk("t3_resp_valid", resp_valid, 1);
                chk("t3_resp_id", resp_id, 64'(exp_t3[c]));
            end else begin
                chk("t3_resp_idle", resp_valid, 0);
            end
            $display("T3 cycle %0d resp_valid=%0d resp_id=%0d", c, resp_valid, resp_id);
        end
        user_valid = 1'b0;
        tick();
        hit = 1'b0;
        chk("t3_hit_sat", hit_cnt, 3);
        chk("t3_miss_cnt", miss_cnt, 1);

        // Three lookups in flight, then switch to 8'hF0
        for (int c = 0; c < 6; c++) begin
            user_valid = (c < 3);
            user_addr  = 32'(32 + c);
            user_id    = IW'(8 + c);
            os_valid   = (c == 3);
            os_hitmap  = 8'hF0;
            if (c == 3) begin
                #1;
                chk("t4_os_prio", user_ready, 0);
                chk("t4_os_ready", os_ready, 1);
            end
            tick();
            if (exp_t4[c] >= 0) begin
                chk("t4_resp_valid", resp_valid, 1);
                chk("t4_resp_id", resp_id, 64'(exp_t4[c]));
            end else begin
                chk("t4_resp_idle", resp_valid, 0);
            end
            chk("t4_no_os_req", os_req, 0);
            $display("T4 cycle %0d resp_valid=%0d resp_id=%0d os_req=%0d", c, resp_valid, resp_id, os_req);
        end
        os_valid = 1'b0;
        chk("t4_miss_sat", miss_cnt, 3);
        chk("t4_hitmap_old", hitmap, 8'h0F);
        tick();
        chk("t4_os_req", os_req, 1);
        chk("t4_hitmap_new", hitmap, 8'hF0);
        chk("t4_user_req_off", user_req, 0);
        tick();
        chk("t4_os_req_off", os_req, 0);
        chk("t4_hit_clr", hit_cnt, 0);
        chk("t4_miss_clr", miss_cnt, 0);
        chk("t4_user_ready", user_ready, 1);
        $display("T4 domain F0 committed");

        // Zero way mask is dropped with an error pulse
        os_valid  = 1'b1;
        os_hitmap = 8'h00;
        tick();
        os_valid = 1'b0;
        chk("t5_os_err", os_err, 1);
        chk("t5_os_ready", os_ready, 1);
        tick();
        chk("t5_os_err_off", os_err, 0);
        chk("t5_no_os_req", os_req, 0);
        chk("t5_hitmap", hitmap, 8'hF0);
        $display("T5 zero hitmap dropped");

        // Reset while draining with a lookup in flight
        user_valid = 1'b1;
        user_addr  = 32'd7;
        user_id    = 4'd1;
        tick();
        user_valid = 1'b0;
        os_valid   = 1'b1;
        os_hitmap  = 8'h3C;
        tick();
        os_valid = 1'b0;
        chk("t6_drain", os_ready, 0);
        chk("t6_inflight", user_req, 1);
        reset = 1'b1;
        tick();
        chk("t6_rst_resp", resp_valid, 0);
        chk("t6_rst_user_req", user_req, 0);
        chk("t6_rst_domain", domain_valid, 0);
        chk("t6_rst_hitmap", hitmap, 0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t6_post_resp", resp_valid, 0);
            chk("t6_post_user_req", user_req, 0);
            chk("t6_post_os_req", os_req, 0);
        end
        chk("t6_user_ready", user_ready, 0);
        chk("t6_os_ready", os_ready, 1);
        $display("T6 reset during drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cacheline_req_sched
